// File: rtl/pkt_key_parser.sv
// pkt_key_parser
//   Passive tap on a 64-bit AXI-Stream Ethernet feed. For each untagged IPv4/UDP
//   frame that is not a non-first fragment it emits one 96-bit flow key
//   {src IPv4, dst IPv4, UDP dst port, 16'h0000} plus DNS hint flags. It also
//   counts the frames it sees and the keys it emits.
//
//   Optional feature macro: PKT_KEY_PARSER_VLAN_EN. When defined, a single
//   802.1Q tag (0x8100 at bytes 12-13) is recognised and every later header
//   field is read 4 bytes further on.
//
// Ports
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset
//   s_axis_tdata   : frame data, byte 0 in bits [7:0]
//   s_axis_tkeep   : byte enables
//   s_axis_tvalid  : beat valid
//   s_axis_tready  : beat ready (observed only; a beat counts when valid & ready)
//   s_axis_tlast   : last beat of frame
//   out_key        : {src IP, dst IP, UDP dst port, 16'h0}, network byte order
//   out_flag       : [0] key present, [1] dport==53, [2] sport==53, [3] 0
//   out_valid      : one-cycle pulse when out_key/out_flag are refreshed
//   out_pkt_cnt    : frames seen (accepted tlast beats), wraps
//   out_key_cnt    : keys emitted, wraps
module pkt_key_parser #(
    parameter int KEY_SIZE   = 96,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [KEY_SIZE-1:0]       out_key,
    output logic [3:0]                out_flag,
    output logic                      out_valid,
    output logic [31:0]               out_pkt_cnt,
    output logic [31:0]               out_key_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [2:0]   r_beat;        // index of the next accepted beat, saturates at 7
    logic [63:0]  r_b1;
    logic [63:0]  r_b2;
    logic [63:0]  r_b3;
`ifdef PKT_KEY_PARSER_VLAN_EN
    logic [63:0]  r_b4;
`endif
    logic [95:0]  r_key;
    logic [3:0]   r_flag;
    logic         r_valid;
    logic [31:0]  r_pkt_cnt;
    logic [31:0]  r_key_cnt;

    logic         w_acc;
    logic [511:0] w_frame;
    logic         w_tagged;
    logic [5:0]   w_off;
    logic [2:0]   w_key_idx;
    logic         w_keep_ok;
    logic         w_at_key;
    logic         w_qual;
    logic         w_emit;
    logic [15:0]  w_etype;
    logic [15:0]  w_frag;
    logic [15:0]  w_sport;
    logic [15:0]  w_dport;
    logic [7:0]   w_vihl;
    logic [7:0]   w_proto;
    logic [31:0]  w_src;
    logic [31:0]  w_dst;
    logic [95:0]  w_key;
    logic [3:0]   w_flag;
    logic         w_unused_keep;

    function automatic logic [7:0] fbyte(input logic [511:0] f, input logic [5:0] idx);
        return f[{idx, 3'b000} +: 8];
    endfunction

    assign w_acc = s_axis_tvalid & s_axis_tready;

    // Header image as seen on the key beat: stored beats 1.. plus the live
    // beat. Beat 0 holds only MAC addresses and is never needed.
    always_comb begin
        w_frame          = '0;
        w_frame[127:64]  = r_b1;
        w_frame[191:128] = r_b2;
        w_frame[255:192] = r_b3;
`ifdef PKT_KEY_PARSER_VLAN_EN
        w_frame[319:256] = (r_beat == 3'd4) ? s_axis_tdata : r_b4;
        w_frame[383:320] = s_axis_tdata;
`else
        w_frame[319:256] = s_axis_tdata;
`endif
    end

`ifdef PKT_KEY_PARSER_VLAN_EN
    assign w_tagged = ({fbyte(w_frame, 6'd12), fbyte(w_frame, 6'd13)} == 16'h8100);
`else
    assign w_tagged = 1'b0;
`endif

    assign w_off     = w_tagged ? 6'd4 : 6'd0;
    assign w_key_idx = w_tagged ? 3'd5 : 3'd4;
    // Byte 37 (41 when tagged) is the last key byte; it sits in lane 5 (lane 1).
    assign w_keep_ok = w_tagged ? s_axis_tkeep[1] : s_axis_tkeep[5];
    assign w_at_key  = (r_beat == w_key_idx);
    assign w_unused_keep = ^s_axis_tkeep;

    assign w_etype = {fbyte(w_frame, 6'd12 + w_off), fbyte(w_frame, 6'd13 + w_off)};
    assign w_vihl  = fbyte(w_frame, 6'd14 + w_off);
    assign w_frag  = {fbyte(w_frame, 6'd20 + w_off), fbyte(w_frame, 6'd21 + w_off)};
    assign w_proto = fbyte(w_frame, 6'd23 + w_off);
    assign w_src   = {fbyte(w_frame, 6'd26 + w_off), fbyte(w_frame, 6'd27 + w_off),
                      fbyte(w_frame, 6'd28 + w_off), fbyte(w_frame, 6'd29 + w_off)};
    assign w_dst   = {fbyte(w_frame, 6'd30 + w_off), fbyte(w_frame, 6'd31 + w_off),
                      fbyte(w_frame, 6'd32 + w_off), fbyte(w_frame, 6'd33 + w_off)};
    assign w_sport = {fbyte(w_frame, 6'd34 + w_off), fbyte(w_frame, 6'd35 + w_off)};
    assign w_dport = {fbyte(w_frame, 6'd36 + w_off), fbyte(w_frame, 6'd37 + w_off)};

    // Offset is the low 13 bits; DF/MF alone do not disqualify a frame.
    assign w_qual = (w_etype == 16'h0800) && (w_vihl == 8'h45) &&
                    (w_proto == 8'd17) && (w_frag[12:0] == 13'd0);

    assign w_key  = {w_src, w_dst, w_dport, 16'h0000};
    assign w_flag = {1'b0, (w_sport == 16'd53), (w_dport == 16'd53), 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = s_axis_tlast ? S_IDLE : S_HDR;
                end
            end
            S_HDR: begin
                if (w_acc) begin
                    if (w_at_key) begin
                        w_emit      = w_qual && (!s_axis_tlast || w_keep_ok);
                        w_state_nxt = s_axis_tlast ? S_IDLE : S_DRAIN;
                    end else if (s_axis_tlast) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (w_acc && s_axis_tlast) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= 3'd0;
        end else if (w_acc) begin
            if (s_axis_tlast) begin
                r_beat <= 3'd0;
            end else if (r_beat != 3'd7) begin
                r_beat <= r_beat + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc && (r_state == S_HDR)) begin
            case (r_beat)
                3'd1: r_b1 <= s_axis_tdata;
                3'd2: r_b2 <= s_axis_tdata;
                3'd3: r_b3 <= s_axis_tdata;
`ifdef PKT_KEY_PARSER_VLAN_EN
                3'd4: r_b4 <= s_axis_tdata;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_key     <= '0;
            r_flag    <= '0;
            r_pkt_cnt <= '0;
            r_key_cnt <= '0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_key     <= w_key;
                r_flag    <= w_flag;
                r_key_cnt <= r_key_cnt + 32'd1;
            end
            if (w_acc && s_axis_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign out_key     = r_key;
    assign out_flag    = r_flag;
    assign out_valid   = r_valid;
    assign out_pkt_cnt = r_pkt_cnt;
    assign out_key_cnt = r_key_cnt;

endmodule

// File: tb/tb_pkt_key_parser.sv
`timescale 1ns/1ps
module tb_pkt_key_parser;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [95:0] out_key;
    logic [3:0]  out_flag;
    logic        out_valid;
    logic [31:0] out_pkt_cnt;
    logic [31:0] out_key_cnt;

    pkt_key_parser #(.KEY_SIZE(96), .DATA_WIDTH(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .out_key       (out_key),
        .out_flag      (out_flag),
        .out_valid     (out_valid),
        .out_pkt_cnt   (out_pkt_cnt),
        .out_key_cnt   (out_key_cnt)
    );

`ifdef PKT_KEY_PARSER_VLAN_EN
    localparam bit VLAN_ON = 1'b1;
`else
    localparam bit VLAN_ON = 1'b0;
`endif

    typedef struct {
        bit          vlan;
        logic [15:0] etype;
        logic [7:0]  vihl;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] sport;
        logic [15:0] dport;
        int          nbeats;
        logic [7:0]  keep;
        bit          exp_v;
        logic [95:0] exp_key;
        logic [3:0]  exp_flag;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          npulse = 0;
    int          nterr = 0;
    logic        tb_keybeat = 1'b0;
    logic        key_acc_d = 1'b0;
    logic [7:0]  fb [0:127];
    int          p0, t0, kb, exp_pkt, exp_kc;
    logic [95:0] exp_last_key;
    logic [3:0]  exp_last_flag;

    // key_acc_d is high in the cycle right after the key beat was accepted.
    always @(posedge clk) key_acc_d <= tb_keybeat && s_axis_tvalid && s_axis_tready && !rst;

    always @(negedge clk) begin
        if (out_valid) begin
            npulse++;
            if (!key_acc_d) nterr++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int exp_pulses);
        check({tag, " pulses"},   96'(npulse - p0), 96'(exp_pulses));
        check({tag, " timing"},   96'(nterr - t0), 96'd0);
        check({tag, " out_key"},  out_key, exp_last_key);
        check({tag, " out_flag"}, 96'(out_flag), 96'(exp_last_flag));
        check({tag, " pkt_cnt"},  96'(out_pkt_cnt), 96'(exp_pkt));
        check({tag, " key_cnt"},  96'(out_key_cnt), 96'(exp_kc));
    endtask

    task automatic build_frame(input bit vlan, input logic [15:0] etype, input logic [7:0] vihl,
                               input logic [15:0] frag, input logic [7:0] proto,
                               input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] sport, input logic [15:0] dport);
        int o;
        for (int i = 0; i < 128; i++) fb[i] = 8'(i) ^ 8'h5A;
        o = vlan ? 4 : 0;
        if (vlan) begin
            fb[12] = 8'h81; fb[13] = 8'h00; fb[14] = 8'h00; fb[15] = 8'h64;
        end
        fb[12+o] = etype[15:8]; fb[13+o] = etype[7:0];
        fb[14+o] = vihl;
        fb[20+o] = frag[15:8];  fb[21+o] = frag[7:0];
        fb[23+o] = proto;
        fb[26+o] = src[31:24];  fb[27+o] = src[23:16]; fb[28+o] = src[15:8]; fb[29+o] = src[7:0];
        fb[30+o] = dst[31:24];  fb[31+o] = dst[23:16]; fb[32+o] = dst[15:8]; fb[33+o] = dst[7:0];
        fb[34+o] = sport[15:8]; fb[35+o] = sport[7:0];
        fb[36+o] = dport[15:8]; fb[37+o] = dport[7:0];
    endtask

    task automatic load_beat(input int b);
        for (int i = 0; i < 8; i++) s_axis_tdata[8*i +: 8] = fb[8*b+i];
    endtask

    task automatic drive_beat(input int b, input bit last, input logic [7:0] keep, input bit keyb);
        load_beat(b);
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b1;
        tb_keybeat    = keyb;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tb_keybeat    = 1'b0;
    endtask

    // Idle cycles carry garbage data and tlast so that ignoring them is tested.
    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tkeep  = 8'h00;
        s_axis_tready = 1'($urandom);
        tb_keybeat    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input logic [7:0] last_keep, input int keyb,
                              input int gap, input int stall_beat, input int stall_len);
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0 && gap > 0) idle(gap);
            if (b == stall_beat) begin
                load_beat(b);
                s_axis_tkeep  = (b == nbeats - 1) ? last_keep : 8'hFF;
                s_axis_tlast  = (b == nbeats - 1);
                s_axis_tvalid = 1'b1;
                s_axis_tready = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            drive_beat(b, (b == nbeats - 1), (b == nbeats - 1) ? last_keep : 8'hFF, (b == keyb));
        end
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;

        vecs[0]  = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h0A000002, 16'h0035, 16'h04D2, 6, 8'hFF, 1'b1, 96'h0A000001_0A000002_04D2_0000, 4'b0101};
        vecs[1]  = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h06, 32'hC0A80001, 32'hC0A80002, 16'h0035, 16'h0035, 6, 8'hFF, 1'b0, 96'h0, 4'h0};
        vecs[2]  = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'hC0A80001, 32'hC0A80002, 16'h04D2, 16'h0035, 6, 8'hFF, 1'b1, 96'hC0A80001_C0A80002_0035_0000, 4'b0011};
        vecs[3]  = '{1'b0, 16'h86DD, 8'h45, 16'h0000, 8'h11, 32'h01010101, 32'h02020202, 16'h0035, 16'h0035, 6, 8'hFF, 1'b0, 96'h0, 4'h0};
        vecs[4]  = '{1'b0, 16'h0800, 8'h46, 16'h0000, 8'h11, 32'h01010101, 32'h02020202, 16'h0035, 16'h0035, 6, 8'hFF, 1'b0, 96'h0, 4'h0};
        vecs[5]  = '{1'b0, 16'h0800, 8'h45, 16'h0001, 8'h11, 32'h01010101, 32'h02020202, 16'h0035, 16'h0035, 6, 8'hFF, 1'b0, 96'h0, 4'h0};
        vecs[6]  = '{1'b0, 16'h0800, 8'h45, 16'h3000, 8'h11, 32'h01010101, 32'h02020202, 16'h0035, 16'h0035, 6, 8'hFF, 1'b0, 96'h0, 4'h0};
        vecs[7]  = '{1'b0, 16'h0800, 8'h45, 16'h4000, 8'h11, 32'hAC100005, 32'hAC10000A, 16'h03E8, 16'h07D0, 6, 8'hFF, 1'b1, 96'hAC100005_AC10000A_07D0_0000, 4'b0001};
        vecs[8]  = '{1'b0, 16'h0800, 8'h45, 16'h2000, 8'h11, 32'h01020304, 32'h05060708, 16'h0035, 16'h0035, 6, 8'hFF, 1'b1, 96'h01020304_05060708_0035_0000, 4'b0111};
        vecs[9]  = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A0A0A0A, 32'h14141414, 16'h1111, 16'h2222, 5, 8'h3F, 1'b1, 96'h0A0A0A0A_14141414_2222_0000, 4'b0001};
        vecs[10] = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A0A0A0B, 32'h14141415, 16'h1111, 16'h3333, 5, 8'h1F, 1'b0, 96'h0, 4'h0};
        vecs[11] = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A0A0A0C, 32'h14141416, 16'h1111, 16'h4444, 4, 8'hFF, 1'b0, 96'h0, 4'h0};
        vecs[12] = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A0A0A0D, 32'h14141417, 16'h1111, 16'h5555, 1, 8'hFF, 1'b0, 96'h0, 4'h0};
        vecs[13] = '{1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0B000001, 32'h0B000002, 16'h0035, 16'h1F90, 12, 8'hFF, 1'b1, 96'h0B000001_0B000002_1F90_0000, 4'b0101};
        vecs[14] = '{1'b1, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'hC6336401, 32'hC6336402, 16'h14E9, 16'h0035, 7, 8'hFF, VLAN_ON, 96'hC6336401_C6336402_0035_0000, 4'b0011};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out_valid", 96'(out_valid), 96'd0);
        check("reset out_key",   out_key, 96'd0);
        check("reset out_flag",  96'(out_flag), 96'd0);
        check("reset pkt_cnt",   96'(out_pkt_cnt), 96'd0);
        check("reset key_cnt",   96'(out_key_cnt), 96'd0);
        exp_pkt = 0; exp_kc = 0; exp_last_key = '0; exp_last_flag = '0;
        idle(2);

        for (int r = 0; r < NV; r++) begin
            build_frame(vecs[r].vlan, vecs[r].etype, vecs[r].vihl, vecs[r].frag, vecs[r].proto,
                        vecs[r].src, vecs[r].dst, vecs[r].sport, vecs[r].dport);
            p0 = npulse; t0 = nterr;
            kb = (vecs[r].vlan && VLAN_ON) ? 5 : 4;
            send_frame(vecs[r].nbeats, vecs[r].keep, kb, 0, -1, 0);
            idle(3);
            exp_pkt++;
            if (vecs[r].exp_v) begin
                exp_kc++;
                exp_last_key  = vecs[r].exp_key;
                exp_last_flag = vecs[r].exp_flag;
            end
            expect_state($sformatf("vec%0d", r), vecs[r].exp_v ? 1 : 0);
        end

        // TCP frame immediately followed by a UDP dport-53 frame
        p0 = npulse; t0 = nterr;
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h06, 32'h0A000061, 32'h0A000062, 16'h04D2, 16'h0035);
        send_frame(6, 8'hFF, 4, 0, -1, 0);
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000063, 32'h0A000064, 16'h04D2, 16'h0035);
        send_frame(6, 8'hFF, 4, 0, -1, 0);
        idle(3);
        exp_pkt += 2; exp_kc += 1;
        exp_last_key = 96'h0A000063_0A000064_0035_0000; exp_last_flag = 4'b0011;
        expect_state("tcp_then_udp", 1);

        // Gaps of two idle cycles between beats and a 3-cycle tready stall on beat 3
        p0 = npulse; t0 = nterr;
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h0A000002, 16'h0035, 16'h04D2);
        send_frame(6, 8'hFF, 4, 2, 3, 3);
        idle(3);
        exp_pkt += 1; exp_kc += 1;
        exp_last_key = 96'h0A000001_0A000002_04D2_0000; exp_last_flag = 4'b0101;
        expect_state("stalled", 1);

        // Key-beat tlast frame immediately followed by another frame
        p0 = npulse; t0 = nterr;
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A0A0A0A, 32'h14141414, 16'h1111, 16'h2222);
        send_frame(5, 8'h3F, 4, 0, -1, 0);
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000005, 32'h0A000006, 16'h0035, 16'h0101);
        send_frame(6, 8'hFF, 4, 0, -1, 0);
        idle(3);
        exp_pkt += 2; exp_kc += 2;
        exp_last_key = 96'h0A000005_0A000006_0101_0000; exp_last_flag = 4'b0101;
        expect_state("b2b_keylast", 2);

        // Reset asserted on beat 2 of a qualifying frame
        p0 = npulse; t0 = nterr;
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h0A000002, 16'h0035, 16'h04D2);
        drive_beat(0, 1'b0, 8'hFF, 1'b0);
        drive_beat(1, 1'b0, 8'hFF, 1'b0);
        load_beat(2);
        s_axis_tkeep = 8'hFF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1; s_axis_tready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_axis_tvalid = 1'b0;
        exp_pkt = 0; exp_kc = 0; exp_last_key = '0; exp_last_flag = '0;
        check("midrst out_valid", 96'(out_valid), 96'd0);
        expect_state("midrst", 0);
        idle(2);
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000007, 32'h0A000008, 16'h3039, 16'h0050);
        send_frame(6, 8'hFF, 4, 0, -1, 0);
        idle(3);
        exp_pkt = 1; exp_kc = 1;
        exp_last_key = 96'h0A000007_0A000008_0050_0000; exp_last_flag = 4'b0001;
        expect_state("after_rst", 1);

        // Short frames: tlast on beat 3, then tlast on beat 4 with tkeep 0x1F
        p0 = npulse; t0 = nterr;
        build_frame(1'b0, 16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h0A000002, 16'h0035, 16'h04D2);
        send_frame(4, 8'hFF, 4, 0, -1, 0);
        send_frame(5, 8'h1F, 4, 0, -1, 0);
        idle(3);
        exp_pkt += 2;
        expect_state("short", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
